// File: rtl/ctrl_debouncer.sv
// ctrl_debouncer: conditions a raw, bouncing push-button into clean control
// signals. A two-flop synchronizer feeds a four-state debounce FSM with a
// stability counter; all outputs are registered.
//   ctrl      : step select for count_especial (1 = +2, 0 = +1)
//   btn_level : debounced button level
//   btn_pulse : one-cycle strobe per accepted press
module ctrl_debouncer #(
  parameter int DB_CYCLES = 16,  // stable synced samples needed to accept an edge (>= 2)
  parameter bit TOGGLE    = 1'b1 // 1: ctrl toggles per press, 0: ctrl follows btn_level
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic ctrl,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    PRESSED   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic          sync_ff1;
  logic          sync_ff2;
  logic          s;
  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] next_cnt;
  logic          next_level;
  logic          accept_press;

  assign s = sync_ff2;

  // Two-flop synchronizer bringing the asynchronous button into the clk domain.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; with = the second flop would copy
  // btn_in directly and the synchronizer would collapse to a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= btn_in;
      sync_ff2 <= sync_ff1;
    end
  end

  // Next-state and stability-counter logic of the debounce FSM.
  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned; an unassigned path would infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (s) begin
          next_state = WAIT_HIGH;
          next_cnt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = PRESSED;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          next_state = WAIT_LOW;
          next_cnt   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          // Bounce during release: fall straight back to PRESSED, no pulse.
          next_state = PRESSED;
        end else if (cnt == CNT_LAST) begin
          next_state = IDLE;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Decoded values that the output registers capture on the state edge.
  assign next_level   = (next_state == PRESSED) || (next_state == WAIT_LOW);
  assign accept_press = (state == WAIT_HIGH) && (next_state == PRESSED);

  // FSM state, counter and registered outputs, all updating on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ctrl      <= 1'b0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      btn_level <= next_level;
      btn_pulse <= accept_press;
      if (TOGGLE) begin
        if (accept_press) begin
          ctrl <= ~ctrl;
        end
      end else begin
        ctrl <= next_level;
      end
    end
  end

endmodule
